mem_arbiter: RTL

//  Line-granular main-memory model with a two-port arbiter. It sits downstream of the I-cache
//  and of the D-cache memory interface (out_mem_* / in_mem_*) and serves one cache-line

---
 rtl/mem_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Line-granular backing store with a D-over-I fixed-priority arbiter.
// One line transaction is served at a time; the ready pulse arrives a fixed latency after acceptance.
module mem_arbiter #(
  parameter int CACHE_LINE_SIZE = 128,
  parameter int MEM_LATENCY     = 5,
  parameter int MEM_LINES       = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_imem_read_en,
  input  logic [31:0]                in_imem_addr,
  output logic [CACHE_LINE_SIZE-1:0] out_imem_read_data,
  output logic                       out_imem_ready,
  input  logic                       in_dmem_read_en,
  input  logic                       in_dmem_write_en,
  input  logic [31:0]                in_dmem_addr,
  input  logic [CACHE_LINE_SIZE-1:0] in_dmem_write_data,
  output logic [CACHE_LINE_SIZE-1:0] out_dmem_read_data,
  output logic                       out_dmem_ready
);
  localparam int OFF = $clog2(CACHE_LINE_SIZE / 8);
  localparam int LW  = $clog2(MEM_LINES);
  localparam int CW  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LATENCY - 1);
  localparam bit SINGLE = (MEM_LATENCY == 1);

  generate
    if (MEM_LATENCY < 1) begin : g_bad_latency
      $error("mem_arbiter: MEM_LATENCY must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                     state_reg;
  logic [CW-1:0]              count_reg;
  logic                       grant_d_reg;
  logic                       op_write_reg;
  logic [LW-1:0]              line_reg;
  logic [CACHE_LINE_SIZE-1:0] wdata_reg;
  logic [CACHE_LINE_SIZE-1:0] mem_reg [MEM_LINES];

  logic                       req_any, req_d, req_wr;
  logic [LW-1:0]              req_line;
  logic                       access, acc_d, acc_wr;
  logic [LW-1:0]              acc_line;
  logic [CACHE_LINE_SIZE-1:0] acc_wdata;
  logic                       unused_addr_bits;

  assign unused_addr_bits = ^{in_imem_addr[31:OFF+LW], in_imem_addr[OFF-1:0],
                              in_dmem_addr[31:OFF+LW], in_dmem_addr[OFF-1:0]};

  // The array access happens on the edge that enters RESP; with unit latency that is the accept edge,
  // so the live request fields are used instead of the latched ones.
  always_comb begin
    req_d    = in_dmem_write_en | in_dmem_read_en;
    req_wr   = in_dmem_write_en;
    req_any  = req_d | in_imem_read_en;
    req_line = req_d ? in_dmem_addr[OFF +: LW] : in_imem_addr[OFF +: LW];
    if (state_reg == IDLE) begin
      acc_d     = req_d;
      acc_wr    = req_wr;
      acc_line  = req_line;
      acc_wdata = in_dmem_write_data;
      access    = SINGLE && req_any;
    end else begin
      acc_d     = grant_d_reg;
      acc_wr    = op_write_reg;
      acc_line  = line_reg;
      acc_wdata = wdata_reg;
      access    = (state_reg == BUSY) && (count_reg == CW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset && access && acc_wr) begin
      mem_reg[acc_line] <= acc_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg          <= IDLE;
      count_reg          <= '0;
      grant_d_reg        <= 1'b0;
      op_write_reg       <= 1'b0;
      line_reg           <= '0;
      wdata_reg          <= '0;
      out_imem_ready     <= 1'b0;
      out_dmem_ready     <= 1'b0;
      out_imem_read_data <= '0;
      out_dmem_read_data <= '0;
    end else begin
      out_imem_ready <= 1'b0;
      out_dmem_ready <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_any) begin
            grant_d_reg  <= req_d;
            op_write_reg <= req_wr;
            line_reg     <= req_line;
            wdata_reg    <= in_dmem_write_data;
            count_reg    <= CNT_LOAD;
            state_reg    <= SINGLE ? RESP : BUSY;
          end
        end
        BUSY: begin
          count_reg <= count_reg - CW'(1);
          if (count_reg == CW'(1)) begin
            state_reg <= RESP;
          end
        end
        RESP:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
      if (access) begin
        out_dmem_ready <= acc_d;
        out_imem_ready <= !acc_d;
        if (!acc_wr) begin
          if (acc_d) out_dmem_read_data <= mem_reg[acc_line];
          else       out_imem_read_data <= mem_reg[acc_line];
        end
      end
    end
  end
endmodule
